// File: rtl/usb_rx_line_decoder_pkg.sv
// Shared types and default timing constants for the USB full-speed RX line decoder.
// Exports: line_state_t (J/K/SE0/SE1), dec_state_t (decoder FSM states),
//   DEF_* default parameters and line_state() to classify a synchronised D+/D- pair.
package usb_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 8;  // clk cycles per 12 Mb/s bit
  localparam int DEF_SAMPLE_PT    = 3;  // phase at which the line is sampled
  localparam int DEF_STUFF_LIMIT  = 6;  // run of 1s after which a stuffed 0 follows

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_RUN  = 2'd1,
    DEC_SE0  = 2'd2
  } dec_state_t;

  // Full-speed signalling: J = D+ high, K = D- high.
  function automatic line_state_t line_state(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_line_decoder_if.sv
// Bundle between the USB line pins, the line decoder and its consumers.
// master: the decoder (takes d_plus/d_minus, drives edge/eop/bit/error pulses).
// slave : the opposite side (drives the pins, observes the decoder pulses).
interface usb_rx_line_decoder_if;
  logic d_plus;
  logic d_minus;
  logic d_edge;
  logic eop;
  logic shift_strobe;
  logic d_orig;
  logic stuff_err;
  logic line_err;

  modport master (
    input  d_plus, d_minus,
    output d_edge, eop, shift_strobe, d_orig, stuff_err, line_err
  );

  modport slave (
    output d_plus, d_minus,
    input  d_edge, eop, shift_strobe, d_orig, stuff_err, line_err
  );
endinterface

// File: rtl/usb_rx_line_decoder_sync2.sv
// Two-flop synchroniser for one asynchronous line, with a configurable reset value.
// Ports: clk, n_rst (async active-low), async_in (raw pin), sync_out (2 clk later).
// No handshake; output simply follows the input after two clock edges.
module usb_rx_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/usb_rx_line_decoder.sv
// USB 1.1 full-speed RX front end: synchronise D+/D-, recover bit timing from D+ edges,
//   NRZI-decode and strip stuffed bits; all pulses are 1 clk wide and registered.
// Ports: clk, n_rst (async active-low), bus (master modport: d_plus/d_minus in;
//   d_edge, eop, shift_strobe, d_orig, stuff_err, line_err out).
module usb_rx_line_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PT    = DEF_SAMPLE_PT,
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  usb_rx_line_decoder_if.master bus
);

  localparam int PH_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_PT);
  localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(STUFF_LIMIT);

  // ---------------------------------------------------------------------------
  // Synchronisers (idle line = J) plus one extra stage for edge detection.
  // ---------------------------------------------------------------------------
  logic dp_sync, dm_sync;
  logic dp_q, dm_q;

  usb_rx_sync2 #(.RST_VAL(1'b1)) u_sync_dp (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (bus.d_plus),
    .sync_out (dp_sync)
  );

  usb_rx_sync2 #(.RST_VAL(1'b0)) u_sync_dm (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (bus.d_minus),
    .sync_out (dm_sync)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_q <= 1'b1;
      dm_q <= 1'b0;
    end else begin
      dp_q <= dp_sync;
      dm_q <= dm_sync;
    end
  end

  // Combinational precursor of d_edge. Acting on it directly lets the phase
  // counter read 0 in the very cycle the registered d_edge is high.
  logic edge_now;
  assign edge_now = dp_sync ^ dp_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  dec_state_t        state, state_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic [ONES_W-1:0] ones, ones_nxt;
  logic              prev_dp, prev_dp_nxt;

  logic d_edge_r;
  logic eop_r, eop_nxt;
  logic strobe_r, strobe_nxt;
  logic d_orig_r, d_orig_nxt;
  logic stuff_err_r, stuff_err_nxt;
  logic line_err_r, line_err_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= DEC_IDLE;
      phase       <= '0;
      ones        <= '0;
      prev_dp     <= 1'b1;
      d_edge_r    <= 1'b0;
      eop_r       <= 1'b0;
      strobe_r    <= 1'b0;
      d_orig_r    <= 1'b0;
      stuff_err_r <= 1'b0;
      line_err_r  <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      ones        <= ones_nxt;
      prev_dp     <= prev_dp_nxt;
      d_edge_r    <= edge_now;
      eop_r       <= eop_nxt;
      strobe_r    <= strobe_nxt;
      d_orig_r    <= d_orig_nxt;
      stuff_err_r <= stuff_err_nxt;
      line_err_r  <= line_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sampling, NRZI decode, unstuffing and line-state FSM
  // ---------------------------------------------------------------------------
  line_state_t ls;
  logic        sample;
  logic        nrzi_bit;

  assign ls       = line_state(dp_q, dm_q);
  assign sample   = (phase == PH_SAMPLE) && (state != DEC_IDLE);
  assign nrzi_bit = (dp_q == prev_dp);  // no transition decodes as 1

  always_comb begin
    state_nxt     = state;
    ones_nxt      = ones;
    prev_dp_nxt   = prev_dp;
    eop_nxt       = 1'b0;
    strobe_nxt    = 1'b0;
    d_orig_nxt    = d_orig_r;
    stuff_err_nxt = 1'b0;
    line_err_nxt  = 1'b0;

    case (state)
      DEC_IDLE: begin
        if (edge_now) begin
          state_nxt   = DEC_RUN;
          prev_dp_nxt = 1'b1;
          ones_nxt    = '0;
        end
      end

      DEC_RUN: begin
        if (sample) begin
          case (ls)
            LS_SE0: begin
              // EOP takes priority over any pending stuffed-bit slot.
              eop_nxt   = 1'b1;
              ones_nxt  = '0;
              state_nxt = DEC_SE0;
            end
            LS_SE1: begin
              line_err_nxt = 1'b1;
            end
            default: begin
              prev_dp_nxt = dp_q;
              if (ones < ONES_MAX) begin
                strobe_nxt = 1'b1;
                d_orig_nxt = nrzi_bit;
                ones_nxt   = nrzi_bit ? (ones + ONES_W'(1)) : '0;
              end else begin
                // Stuffed-bit slot: drop it; a 1 here means the sender broke stuffing.
                stuff_err_nxt = nrzi_bit;
                ones_nxt      = '0;
              end
            end
          endcase
        end
      end

      DEC_SE0: begin
        if (sample) begin
          case (ls)
            LS_J:    state_nxt = DEC_IDLE;
            LS_K: begin
              line_err_nxt = 1'b1;
              state_nxt    = DEC_IDLE;
            end
            LS_SE1:  line_err_nxt = 1'b1;
            default: state_nxt = DEC_SE0;
          endcase
        end
      end

      default: state_nxt = DEC_IDLE;
    endcase
  end

  // Phase runs only outside IDLE and realigns on every D+ transition.
  always_comb begin
    if (edge_now || (state_nxt == DEC_IDLE)) begin
      phase_nxt = '0;
    end else if (phase == PH_LAST) begin
      phase_nxt = '0;
    end else begin
      phase_nxt = phase + PH_W'(1);
    end
  end

  assign bus.d_edge       = d_edge_r;
  assign bus.eop          = eop_r;
  assign bus.shift_strobe = strobe_r;
  assign bus.d_orig       = d_orig_r;
  assign bus.stuff_err    = stuff_err_r;
  assign bus.line_err     = line_err_r;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Scoreboard bench for usb_rx_line_decoder: packets are NRZI/bit-stuff encoded from
// payload bits, expected decoder events are queued at build time and a monitor pops
// and compares them whenever the DUT emits a pulse.
module tb_usb_rx_line_decoder;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic n_rst;

  usb_rx_line_decoder_if bus ();

  usb_rx_line_decoder #(
    .CLKS_PER_BIT (8),
    .SAMPLE_PT    (3),
    .STUFF_LIMIT  (6)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_BIT, EV_EOP, EV_STUFF, EV_LINE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    logic     val;
  } ev_t;

  ev_t         exp_q[$];
  line_state_t sym_q[$];
  logic [7:0]  pkt_data[$];

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Pulse vector order: {line_err, stuff_err, eop, shift_strobe}
  function automatic logic [3:0] ev_pulses(input ev_kind_t k);
    case (k)
      EV_BIT:   return 4'b0001;
      EV_EOP:   return 4'b0010;
      EV_STUFF: return 4'b0100;
      default:  return 4'b1000;
    endcase
  endfunction

  function automatic logic dp_of(input line_state_t ls);
    return (ls == LS_J) || (ls == LS_SE1);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [3:0] mon_pulses;
  ev_t        mon_ev;

  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.d_edge) edge_cnt++;
      mon_pulses = {bus.line_err, bus.stuff_err, bus.eop, bus.shift_strobe};
      if (mon_pulses != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got pulses %b, expected none (t=%0t)", mon_pulses, $time);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_kind", int'(mon_pulses), int'(ev_pulses(mon_ev.kind)));
          if (mon_ev.kind == EV_BIT) check("d_orig", int'(bus.d_orig), int'(mon_ev.val));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_ls(input line_state_t ls);
    case (ls)
      LS_J:    begin bus.d_plus = 1'b1; bus.d_minus = 1'b0; end
      LS_K:    begin bus.d_plus = 1'b0; bus.d_minus = 1'b1; end
      LS_SE0:  begin bus.d_plus = 1'b0; bus.d_minus = 1'b0; end
      default: begin bus.d_plus = 1'b1; bus.d_minus = 1'b1; end
    endcase
  endtask

  // SYNC + data (LSB first), optional stuffing, optional SE1 after SYNC,
  // then SE0 SE0 followed by J idle, or by K when k_end is set.
  task automatic build_packet(input bit stuff_en, input bit se1, input bit k_end);
    bit   bits[$];
    logic level;
    int   ones;
    level = 1'b1;
    ones  = 0;
    sym_q.delete();
    for (int i = 0; i < 8; i++) bits.push_back(i == 7);
    foreach (pkt_data[j])
      for (int k = 0; k < 8; k++) bits.push_back(pkt_data[j][k]);
    foreach (bits[i]) begin
      if (!bits[i]) level = ~level;
      sym_q.push_back(level ? LS_J : LS_K);
      push_ev(EV_BIT, bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (stuff_en && ones == 6) begin
        level = ~level;
        sym_q.push_back(level ? LS_J : LS_K);
        ones = 0;
      end
      if (se1 && i == 7) begin
        sym_q.push_back(LS_SE1);
        push_ev(EV_LINE, 1'b0);
      end
    end
    sym_q.push_back(LS_SE0);
    sym_q.push_back(LS_SE0);
    push_ev(EV_EOP, 1'b0);
    if (k_end) begin
      sym_q.push_back(LS_K);
      sym_q.push_back(LS_K);
      push_ev(EV_LINE, 1'b0);
    end else begin
      repeat (3) sym_q.push_back(LS_J);
    end
  endtask

  // Number of D+ transitions, starting from and returning to idle J.
  function automatic int count_edges();
    int   c;
    logic p;
    c = 0;
    p = 1'b1;
    foreach (sym_q[i]) begin
      if (dp_of(sym_q[i]) != p) c++;
      p = dp_of(sym_q[i]);
    end
    if (p != 1'b1) c++;
    return c;
  endfunction

  // Symbols before a D+ transition get 7..9 clk; others exactly 8 clk.
  task automatic play(input int max_syms);
    for (int i = 0; i < sym_q.size() && i < max_syms; i++) begin
      logic nd;
      int   w;
      nd = (i + 1 < sym_q.size()) ? dp_of(sym_q[i+1]) : 1'b1;
      w  = (dp_of(sym_q[i]) != nd) ? int'($urandom_range(7, 9)) : 8;
      drive_ls(sym_q[i]);
      repeat (w) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_packet(input string name, input bit stuff_en, input bit se1, input int req_edges);
    int exp_edges;
    edge_cnt = 0;
    build_packet(stuff_en, se1, 1'b0);
    exp_edges = (req_edges >= 0) ? req_edges : count_edges();
    play(sym_q.size());
    drive_ls(LS_J);
    repeat (40) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_edges"}, edge_cnt, exp_edges);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_d_edge"}, int'(bus.d_edge), 0);
    check({name, "_eop"}, int'(bus.eop), 0);
    check({name, "_strobe"}, int'(bus.shift_strobe), 0);
    check({name, "_d_orig"}, int'(bus.d_orig), 0);
    check({name, "_stuff_err"}, int'(bus.stuff_err), 0);
    check({name, "_line_err"}, int'(bus.line_err), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check_outputs_zero("reset_async");
    exp_q.delete();
    drive_ls(LS_J);
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_rst = 1'b0;
    drive_ls(LS_J);
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    n_rst = 1'b1;
    edge_cnt = 0;
    repeat (100) @(posedge clk);
    #1;
    check("idle_edges", edge_cnt, 0);

    // SYNC only, then EOP: 7 edges in SYNC plus SE0->J.
    pkt_data.delete();
    run_packet("sync_only", 1'b1, 1'b0, 8);

    // 0xFF forces a stuffed bit which must be silently dropped.
    pkt_data.delete();
    pkt_data.push_back(8'hFF);
    run_packet("ff_stuffed", 1'b1, 1'b0, -1);

    // Missing stuffed bit: SYNC's last 1 plus five data 1s, then a sixth 1.
    pkt_data.delete();
    pkt_data.push_back(8'hBF);
    edge_cnt = 0;
    build_packet(1'b0, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_ev(EV_BIT, (i == 7));
    repeat (5) push_ev(EV_BIT, 1'b1);
    push_ev(EV_STUFF, 1'b0);
    push_ev(EV_BIT, 1'b0);
    push_ev(EV_BIT, 1'b1);
    push_ev(EV_EOP, 1'b0);
    play(sym_q.size());
    repeat (40) @(posedge clk);
    #1;
    check("stuff_err_drained", exp_q.size(), 0);
    exp_q.delete();

    // SE1 in the middle of a packet.
    pkt_data.delete();
    pkt_data.push_back(8'($urandom));
    run_packet("se1_mid", 1'b1, 1'b1, -1);

    // Random packets with edge jitter.
    for (int p = 0; p < 10; p++) begin
      pkt_data.delete();
      repeat ($urandom_range(1, 3))
        pkt_data.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_packet("random_pkt", 1'b1, 1'b0, -1);
    end

    // Reset in the middle of a byte, then a clean packet.
    pkt_data.delete();
    pkt_data.push_back(8'h5A);
    pkt_data.push_back(8'hC3);
    build_packet(1'b1, 1'b0, 1'b0);
    play(14);
    do_reset();
    check("post_reset_empty", exp_q.size(), 0);
    pkt_data.delete();
    pkt_data.push_back(8'($urandom));
    run_packet("after_reset", 1'b1, 1'b0, -1);

    // K directly after SE0 gives eop then line_err.
    pkt_data.delete();
    pkt_data.push_back(8'h3C);
    build_packet(1'b1, 1'b0, 1'b1);
    play(sym_q.size());
    repeat (30) @(posedge clk);
    #1;
    check("k_after_se0_drained", exp_q.size(), 0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
